// File: rtl/reg32_avalon_arbiter_if.sv
// Avalon-MM register bus bundle: one address/data/strobe set plus read return and stall.
// Latency: none, wiring only.
// Backpressure: waitrequest from the slave-side agent stalls the requesting agent.
interface reg32_avalon_arbiter_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                  chipselect;
    logic                  write;
    logic                  read;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  waitrequest;

    // Agent that issues transfers (arbiter towards the register block).
    modport master (
        output chipselect,
        output write,
        output read,
        output address,
        output byteenable,
        output writedata,
        input  readdata
    );

    // Agent that accepts transfers (arbiter towards each requester).
    modport slave (
        input  write,
        input  read,
        input  address,
        input  byteenable,
        input  writedata,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/reg32_avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM register slave between two masters.
// Latency: strobe 1 cycle after the request is seen; done 2 (write) or 2+READ_LATENCY (read).
// Backpressure: waitrequest held high on both masters except the single DONE cycle of the grantee.
module reg32_avalon_arbiter #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0
) (
    input  logic                   clock,
    input  logic                   resetn,
    reg32_avalon_arbiter_if.slave  m0,
    reg32_avalon_arbiter_if.slave  m1,
    reg32_avalon_arbiter_if.master s
);
    localparam int BE_W = DATA_W / 8;
    // Counter value in the final wait cycle; only meaningful when READ_LATENCY > 0.
    localparam logic [2:0] LAST_CNT = 3'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic                last_grant;
    logic                grant;
    logic                op_write;
    logic [2:0]          cnt;
    logic [DATA_W-1:0]   rdata;

    logic                cs_q;
    logic                wr_q;
    logic                rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                m0_wait_q;
    logic                m1_wait_q;

    logic                m0_req;
    logic                m1_req;
    logic                any_req;
    logic                pick_m1;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [BE_W-1:0]     sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic                accept;
    logic                capture;

    // Pick the winning master and mux its request fields; write wins over read.
    always_comb begin
        m0_req  = m0.write | m0.read;
        m1_req  = m1.write | m1.read;
        any_req = m0_req | m1_req;
        pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
            pick_m1 = ~last_grant;
        end else begin
            pick_m1 = m1_req;
        end
        sel_write = pick_m1 ? m1.write      : m0.write;
        sel_addr  = pick_m1 ? m1.address    : m0.address;
        sel_be    = pick_m1 ? m1.byteenable : m0.byteenable;
        sel_wdata = pick_m1 ? m1.writedata  : m0.writedata;
        accept    = (state == IDLE) && any_req;
    end

    // Next-state decode and the read-data capture strobe.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (op_write) begin
                    state_nxt = DONE;
                end else if (READ_LATENCY == 0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt == LAST_CNT) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Slave-side strobes and fields: loaded on grant so they are live only during ISSUE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cs_q    <= 1'b1;
            wr_q    <= sel_write;
            rd_q    <= ~sel_write;
            addr_q  <= sel_addr;
            be_q    <= sel_be;
            wdata_q <= sel_wdata;
        end else begin
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end
    end

    // Grant bookkeeping: remember the grantee and its operation, rotate priority on completion.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant      <= 1'b0;
            op_write   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                grant    <= pick_m1;
                op_write <= sel_write;
            end
            if (state == DONE) begin
                last_grant <= grant;
            end
        end
    end

    // Read-latency counter: cleared in ISSUE, counts through RWAIT.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= 3'd0;
        end else if (state == ISSUE) begin
            cnt <= 3'd0;
        end else if (state == RWAIT) begin
            cnt <= cnt + 3'd1;
        end
    end

    // Read-data holding register shared by both masters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= s.readdata;
        end
    end

    // Registered waitrequests: only the grantee drops, and only for the DONE cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m0_wait_q <= 1'b1;
            m1_wait_q <= 1'b1;
        end else begin
            m0_wait_q <= !((state_nxt == DONE) && !grant);
            m1_wait_q <= !((state_nxt == DONE) && grant);
        end
    end

    assign s.chipselect   = cs_q;
    assign s.write        = wr_q;
    assign s.read         = rd_q;
    assign s.address      = addr_q;
    assign s.byteenable   = be_q;
    assign s.writedata    = wdata_q;

    assign m0.waitrequest = m0_wait_q;
    assign m1.waitrequest = m1_wait_q;
    assign m0.readdata    = rdata;
    assign m1.readdata    = rdata;
endmodule

// File: tb/tb_reg32_avalon_arbiter.sv
// Directed bench for the two-master register arbiter at read latencies 0, 2 and 3.
// Latency: n/a.
// Backpressure: masters hold requests until their waitrequest drops.
module tb_reg32_avalon_arbiter;
    logic clock;
    logic rstn;
    logic rstn_c;

    int checks = 0;
    int errors = 0;

    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) a_m0 ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) a_m1 ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) a_s ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) b_m0 ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) b_m1 ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) b_s ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) c_m0 ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) c_m1 ();
    reg32_avalon_arbiter_if #(.ADDR_W(3), .DATA_W(32)) c_s ();

    reg32_avalon_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(0)) dut_a (
        .clock(clock), .resetn(rstn), .m0(a_m0), .m1(a_m1), .s(a_s));
    reg32_avalon_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(2)) dut_b (
        .clock(clock), .resetn(rstn), .m0(b_m0), .m1(b_m1), .s(b_s));
    reg32_avalon_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(3)) dut_c (
        .clock(clock), .resetn(rstn_c), .m0(c_m0), .m1(c_m1), .s(c_s));

    assign a_m0.chipselect = 1'b0;
    assign a_m1.chipselect = 1'b0;
    assign b_m0.chipselect = 1'b0;
    assign b_m1.chipselect = 1'b0;
    assign c_m0.chipselect = 1'b0;
    assign c_m1.chipselect = 1'b0;
    assign a_s.waitrequest = 1'b0;
    assign b_s.waitrequest = 1'b0;
    assign c_s.waitrequest = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Register slave for instance A: byte-enabled writes, combinational read data.
    logic [31:0] mem_a [8];
    always @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) mem_a[i] <= 32'h1111_0000 + i;
            mem_a[5] <= 32'h1234_5678;
        end else if (a_s.chipselect && a_s.write) begin
            for (int i = 0; i < 4; i++)
                if (a_s.byteenable[i]) mem_a[a_s.address][8*i +: 8] <= a_s.writedata[8*i +: 8];
        end
    end
    assign a_s.readdata = a_s.read ? mem_a[a_s.address] : 32'hBAD0_BAD0;

    // Strobe counters for instance A.
    int a_cs_cnt = 0;
    int a_bad    = 0;
    always @(posedge clock) begin
        if (a_s.chipselect) a_cs_cnt <= a_cs_cnt + 1;
        if ((a_s.chipselect && (a_s.write == a_s.read)) ||
            (!a_s.chipselect && (a_s.write || a_s.read))) a_bad <= a_bad + 1;
    end

    // Latency slaves for B and C: valid data only in the final wait cycle.
    int b_cnt = 0;
    int c_cnt = 0;
    always @(posedge clock) begin
        if (b_s.read) b_cnt <= 1;
        else if (b_cnt != 0 && b_cnt < 15) b_cnt <= b_cnt + 1;
        if (c_s.read) c_cnt <= 1;
        else if (c_cnt != 0 && c_cnt < 15) c_cnt <= c_cnt + 1;
    end
    assign b_s.readdata = (b_cnt == 2) ? 32'h1234_5678 : 32'hBAD0_BAD0;
    assign c_s.readdata = (c_cnt == 3) ? 32'hCAFE_F00D : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic a_drive(input int m, input logic wr, input logic rd, input logic [2:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
        if (m == 0) begin
            a_m0.write = wr; a_m0.read = rd; a_m0.address = addr;
            a_m0.byteenable = be; a_m0.writedata = data;
        end else begin
            a_m1.write = wr; a_m1.read = rd; a_m1.address = addr;
            a_m1.byteenable = be; a_m1.writedata = data;
        end
    endtask

    task automatic a_xfer(input int m, input logic wr, input logic rd, input logic [2:0] addr,
                          input logic [3:0] be, input logic [31:0] data,
                          output int lat, output logic [31:0] rdv);
        a_drive(m, wr, rd, addr, be, data);
        lat = 0;
        rdv = '0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick;
            if (((m == 0) ? a_m0.waitrequest : a_m1.waitrequest) == 1'b0) begin
                lat = i;
                rdv = (m == 0) ? a_m0.readdata : a_m1.readdata;
            end
        end
        tick;
        a_drive(m, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
    endtask

    initial begin
        int          lat;
        int          base;
        int          seen;
        int          last_cyc;
        int          order [16];
        logic [31:0] rdv;

        rstn = 1'b1;
        rstn_c = 1'b1;
        a_drive(0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        a_drive(1, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        b_m0.write = 1'b0; b_m0.read = 1'b0; b_m0.address = '0; b_m0.byteenable = '0; b_m0.writedata = '0;
        b_m1.write = 1'b0; b_m1.read = 1'b0; b_m1.address = '0; b_m1.byteenable = '0; b_m1.writedata = '0;
        c_m0.write = 1'b0; c_m0.read = 1'b0; c_m0.address = '0; c_m0.byteenable = '0; c_m0.writedata = '0;
        c_m1.write = 1'b0; c_m1.read = 1'b0; c_m1.address = '0; c_m1.byteenable = '0; c_m1.writedata = '0;

        // Asynchronous reset, checked before any clock edge.
        #2;
        rstn = 1'b0;
        rstn_c = 1'b0;
        #1;
        check("rst_cs", a_s.chipselect, 1'b0);
        check("rst_strobes", {a_s.write, a_s.read}, 2'b00);
        check("rst_fields", {a_s.address, a_s.byteenable, a_s.writedata}, '0);
        check("rst_wait", {a_m0.waitrequest, a_m1.waitrequest}, 2'b11);
        check("rst_rdata", a_m0.readdata, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rstn = 1'b1;
        rstn_c = 1'b1;
        tick;

        // Single write from m0.
        a_drive(0, 1'b1, 1'b0, 3'd3, 4'b0110, 32'hDEAD_BEEF);
        tick;
        check("wr_strobe", {a_s.chipselect, a_s.write, a_s.read}, 3'b110);
        check("wr_fields", {a_s.address, a_s.byteenable, a_s.writedata}, {3'd3, 4'b0110, 32'hDEAD_BEEF});
        check("wr_wait_k1", {a_m0.waitrequest, a_m1.waitrequest}, 2'b11);
        tick;
        check("wr_cs_k2", a_s.chipselect, 1'b0);
        check("wr_wait_k2", {a_m0.waitrequest, a_m1.waitrequest}, 2'b01);
        tick;
        a_drive(0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        check("wr_wait_k3", a_m0.waitrequest, 1'b1);
        check("wr_mem", mem_a[3], 32'h11AD_BE03);

        // Single read from m1, latency 0.
        a_xfer(1, 1'b0, 1'b1, 3'd5, 4'hF, 32'd0, lat, rdv);
        check("rd0_lat", lat, 2);
        check("rd0_data", rdv, 32'h1234_5678);

        // Single read from m1 on instance B, latency 2.
        b_m1.read = 1'b1;
        b_m1.address = 3'd5;
        tick;
        check("rd2_strobe", {b_s.chipselect, b_s.write, b_s.read}, 3'b101);
        tick;
        check("rd2_cs_k2", b_s.chipselect, 1'b0);
        check("rd2_wait_k2", b_m1.waitrequest, 1'b1);
        tick;
        check("rd2_wait_k3", b_m1.waitrequest, 1'b1);
        tick;
        check("rd2_wait_k4", {b_m0.waitrequest, b_m1.waitrequest}, 2'b10);
        check("rd2_data", b_m1.readdata, 32'h1234_5678);
        tick;
        b_m1.read = 1'b0;

        // Simultaneous writes: m0 first, m1 three cycles later.
        base = a_cs_cnt;
        a_drive(0, 1'b1, 1'b0, 3'd1, 4'hF, 32'h1111_AAAA);
        a_drive(1, 1'b1, 1'b0, 3'd2, 4'hF, 32'h2222_BBBB);
        tick;
        check("sim_first", {a_s.chipselect, a_s.address}, {1'b1, 3'd1});
        tick;
        check("sim_done0", {a_m0.waitrequest, a_m1.waitrequest}, 2'b01);
        tick;
        a_drive(0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        check("sim_gap", a_s.chipselect, 1'b0);
        tick;
        check("sim_second", {a_s.chipselect, a_s.address, a_s.writedata}, {1'b1, 3'd2, 32'h2222_BBBB});
        tick;
        check("sim_done1", {a_m0.waitrequest, a_m1.waitrequest}, 2'b10);
        tick;
        a_drive(1, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        check("sim_strobes", a_cs_cnt - base, 2);
        check("sim_mem", {mem_a[1], mem_a[2]}, {32'h1111_AAAA, 32'h2222_BBBB});

        // Continuous contention for 12 transfers.
        a_drive(0, 1'b1, 1'b0, 3'd4, 4'hF, 32'h4040_4040);
        a_drive(1, 1'b1, 1'b0, 3'd7, 4'hF, 32'h7070_7070);
        seen = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 100 && seen < 12; cyc++) begin
            tick;
            if (!a_m0.waitrequest && seen < 16) begin order[seen] = 0; seen++; end
            if (!a_m1.waitrequest && seen < 16) begin order[seen] = 1; seen++; end
            if (seen >= 12) last_cyc = cyc;
        end
        a_drive(0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        a_drive(1, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        check("cont_count", seen, 12);
        check("cont_cycles", last_cyc, 35);
        for (int i = 0; i < 12; i++) check($sformatf("cont_order%0d", i), order[i], i % 2);
        tick;
        tick;

        // Read and write together on m0: treated as a write.
        a_drive(0, 1'b1, 1'b1, 3'd6, 4'hF, 32'hA5A5_A5A5);
        tick;
        check("rw_strobe", {a_s.chipselect, a_s.write, a_s.read}, 3'b110);
        tick;
        check("rw_wait", a_m0.waitrequest, 1'b0);
        tick;
        a_drive(0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0);
        check("rw_mem", mem_a[6], 32'hA5A5_A5A5);
        check("a_total_strobes", a_cs_cnt, 17);
        check("a_bad_strobes", a_bad, 0);

        // Reset in the middle of a latency-3 read on instance C.
        c_m0.read = 1'b1;
        c_m0.address = 3'd2;
        tick;
        check("rr_strobe", {c_s.chipselect, c_s.read}, 2'b11);
        tick;
        tick;
        rstn_c = 1'b0;
        c_m0.read = 1'b0;
        #1;
        check("rr_s_zero", {c_s.chipselect, c_s.write, c_s.read, c_s.address, c_s.byteenable, c_s.writedata}, '0);
        check("rr_wait", {c_m0.waitrequest, c_m1.waitrequest}, 2'b11);
        @(negedge clock);
        rstn_c = 1'b1;
        tick;
        c_m0.read = 1'b1;
        lat = 0;
        rdv = '0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick;
            if (!c_m0.waitrequest) begin
                lat = i;
                rdv = c_m0.readdata;
            end
        end
        tick;
        c_m0.read = 1'b0;
        check("rr_lat", lat, 5);
        check("rr_data", rdv, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
